// File: rtl/exec_pkg.sv
// Shared encodings for the EX stage: mul/div ops, forwarding selects,
// ALU controls and the mul/div sequencer states.
package exec_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_RSV = 2'b11;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/alu.sv
// Core ALU: and/or/add/sub/set-less-than (signed).
module alu
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  output logic [WIDTH-1:0] y
);
  // unused control codes yield zero
  always_comb begin
    case (ctrl)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/md_unit.sv
// Iterative radix-2 multiply / restoring divide with architectural HI/LO.
// Works on magnitudes for DATA_WIDTH steps, then fixes signs and writes HI/LO.
module md_unit
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MD_CNT_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_zero
);
  localparam int DW = DATA_WIDTH;
  localparam logic [MD_CNT_WIDTH-1:0] LAST_STEP = MD_CNT_WIDTH'(DW - 1);

  md_state_e               state;
  md_op_e                  op_q;
  logic [MD_CNT_WIDTH-1:0] cnt;
  logic                    neg_a, neg_b;
  logic [DW-1:0]           a_q, b_mag, acc_hi, acc_lo;

  // operand magnitudes at acceptance; unsigned ops never negate
  md_op_e        op_in;
  logic          sa, sb;
  logic [DW-1:0] a_mag_in, b_mag_in;
  assign op_in    = md_op_e'(op);
  assign sa       = md_is_signed(op_in) & a[DW-1];
  assign sb       = md_is_signed(op_in) & b[DW-1];
  assign a_mag_in = sa ? -a : a;
  assign b_mag_in = sb ? -b : b;

  // shift-add step: acc_hi accumulates, acc_lo holds the multiplier
  logic [DW:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? b_mag : {DW{1'b0}})};

  // restoring step: acc_hi is the remainder, acc_lo shifts dividend out / quotient in
  logic [DW:0]   div_shift;
  logic          div_ok;
  logic [DW-1:0] div_rem;
  assign div_shift = {acc_hi, acc_lo[DW-1]};
  assign div_ok    = div_shift >= {1'b0, b_mag};
  assign div_rem   = div_shift[DW-1:0] - b_mag;

  // sign correction; MIN/-1 falls out naturally as MIN since -MIN wraps to MIN
  logic [2*DW-1:0] prod, prod_s;
  logic [DW-1:0]   quo_s, rem_s;
  assign prod   = {acc_hi, acc_lo};
  assign prod_s = (neg_a ^ neg_b) ? -prod : prod;
  assign quo_s  = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
  assign rem_s  = neg_a ? -acc_hi : acc_hi;

  assign busy = (state != IDLE);

  // sequencer: IDLE accepts, RUN iterates DW times, FIX commits HI/LO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= MD_MULTU;
      cnt      <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      a_q      <= '0;
      b_mag    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            op_q   <= op_in;
            cnt    <= '0;
            neg_a  <= sa;
            neg_b  <= sb;
            a_q    <= a;
            b_mag  <= b_mag_in;
            acc_hi <= '0;
            acc_lo <= a_mag_in;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (!md_is_div(op_q)) begin
            acc_hi <= mul_sum[DW:1];
            acc_lo <= {mul_sum[0], acc_lo[DW-1:1]};
          end else if (div_ok) begin
            acc_hi <= div_rem;
            acc_lo <= {acc_lo[DW-2:0], 1'b1};
          end else begin
            acc_hi <= div_shift[DW-1:0];
            acc_lo <= {acc_lo[DW-2:0], 1'b0};
          end
          if (cnt == LAST_STEP) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          if (!md_is_div(op_q)) begin
            {hi, lo} <= prod_s;
          end else if (b_mag == '0) begin
            hi       <= a_q;
            lo       <= '1;
            div_zero <= 1'b1;
          end else begin
            hi <= rem_s;
            lo <= quo_s;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/mux_2_to_1.sv
// Two-input word mux.
module mux_2_to_1 #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/mux_4_to_1.sv
// Four-input word mux.
module mux_4_to_1 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);
  // plain select; all four legs are real data
  always_comb begin
    case (sel)
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d3;
    endcase
  end
endmodule

// File: rtl/execute_stage_md.sv
// EX stage: forwarding muxes, ALU, RegDst/ALUSrc selection, plus the
// mul/div unit with HI/LO readout and the stall request for HI/LO hazards.
module execute_stage_md
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int MD_CNT_WIDTH  = 6
) (
  input  logic                     i_CLK,
  input  logic                     i_RST_n,
  input  logic [DATA_WIDTH-1:0]    i_SrcAE,
  input  logic [DATA_WIDTH-1:0]    i_SrcBE,
  input  logic [DATA_WIDTH-1:0]    i_ResultW,
  input  logic [DATA_WIDTH-1:0]    i_ALUOutM,
  input  logic [DATA_WIDTH-1:0]    i_SignImmE,
  input  logic [2:0]               i_ALUControlE,
  input  logic [1:0]               i_ForwardAE,
  input  logic [1:0]               i_ForwardBE,
  input  logic                     i_ALUSrcE,
  input  logic                     i_RegDstE,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtE,
  input  logic [RF_ADDR_WIDTH-1:0] i_RdE,
  input  logic                     i_MDStartE,
  input  logic [1:0]               i_MDOpE,
  input  logic                     i_MFHiE,
  input  logic                     i_MFLoE,
  output logic [RF_ADDR_WIDTH-1:0] o_WriteRegE,
  output logic [DATA_WIDTH-1:0]    o_WriteDataE,
  output logic [DATA_WIDTH-1:0]    o_ALUOutE,
  output logic                     o_MDStallE,
  output logic                     o_DivZeroE
);
  logic [DATA_WIDTH-1:0] src_a, src_b, alu_y, hi, lo;
  logic                  md_busy;

  // reserved forward code 11 falls back to the register operand
  mux_4_to_1 #(.WIDTH(DATA_WIDTH)) u_fwd_a (
    .sel(i_ForwardAE), .d0(i_SrcAE), .d1(i_ResultW), .d2(i_ALUOutM), .d3(i_SrcAE), .y(src_a)
  );

  mux_4_to_1 #(.WIDTH(DATA_WIDTH)) u_fwd_b (
    .sel(i_ForwardBE), .d0(i_SrcBE), .d1(i_ResultW), .d2(i_ALUOutM), .d3(i_SrcBE), .y(o_WriteDataE)
  );

  mux_2_to_1 #(.WIDTH(DATA_WIDTH)) u_alusrc (
    .sel(i_ALUSrcE), .d0(o_WriteDataE), .d1(i_SignImmE), .y(src_b)
  );

  mux_2_to_1 #(.WIDTH(RF_ADDR_WIDTH)) u_regdst (
    .sel(i_RegDstE), .d0(i_RtE), .d1(i_RdE), .y(o_WriteRegE)
  );

  alu #(.WIDTH(DATA_WIDTH)) u_alu (
    .a(src_a), .b(src_b), .ctrl(i_ALUControlE), .y(alu_y)
  );

  // only HI/LO consumers and a second mul/div wait on a busy unit
  assign o_MDStallE = md_busy & (i_MDStartE | i_MFHiE | i_MFLoE);

  md_unit #(.DATA_WIDTH(DATA_WIDTH), .MD_CNT_WIDTH(MD_CNT_WIDTH)) u_md (
    .clk     (i_CLK),
    .rst_n   (i_RST_n),
    .start   (i_MDStartE & ~o_MDStallE),
    .op      (i_MDOpE),
    .a       (src_a),
    .b       (o_WriteDataE),
    .busy    (md_busy),
    .hi      (hi),
    .lo      (lo),
    .div_zero(o_DivZeroE)
  );

  assign o_ALUOutE = i_MFHiE ? hi : (i_MFLoE ? lo : alu_y);
endmodule
